mux_rr_arb: RTL and testbench
=============================

# mux_rr_arb

Parametrised N:1 arbitrating multiplexer with a registered output stage. N producer channels of W-bit data, each with a valid/ready handshake, share one consumer port. A round-robin arbiter selects one channel per accepted beat. The selected data and channel index are held in an output register until the consumer takes them. This block replaces fixed-select combinational muxing wherever several sources contend for one sink.

## Interface
- `W`, default 4: data width per channel, ≥1.
- `N`, default 4: channel count, ≥2; non-power-of-two values supported.
- `SW`, default `$clog2(N)`: width of the select/index field; localparam, not overridable.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input N: bit i set means channel i presents a beat.
- `in_data` input N*W: channel i data in bits [i*W +: W].
- `in_ready` output N: one-hot or zero; bit i set means channel i's beat is accepted this cycle.
- `out_valid` output 1: output register holds a beat.
- `out_data` output W: held data.
- `out_sel` output SW: index of the channel that supplied `out_data`.
- `out_ready` input 1: consumer accepts the beat when `out_valid && out_ready`.

## Operation
- Output register state is EMPTY (`out_valid`=0) or FULL (`out_valid`=1). There is no other FSM state.
- Load enable: `load = !out_valid || out_ready`.
- Grant is computed combinationally from `in_valid` and the priority pointer `ptr` (SW bits).
- Round-robin rule: the granted channel is the first i with `in_valid[i]`=1, scanning `ptr`, `ptr+1`, … modulo N.
- `in_ready[g] = load && in_valid[g]` for the granted g; all other bits are 0.
- `in_ready` does not depend on `out_ready` when EMPTY.
- On accept (any `in_ready` bit set):
  - `out_data` ← `in_data[g]`
  - `out_sel` ← g
  - `out_valid` ← 1
  - `ptr` ← g+1, wrapping to 0 when g = N-1
- On a drain (`out_valid && out_ready`) with no accept in the same cycle: `out_valid` ← 0; `out_data` and `out_sel` hold their last values.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge, and `out_valid` stays 1. This gives full throughput of 1 beat/cycle.
- While FULL and `out_ready`=0:
  - `out_data`, `out_sel` and `out_valid` are stable.
  - `in_ready`=0 and `ptr` is unchanged.
- Producer rule: a producer must keep `in_valid` and its data stable until accepted. The arbiter tolerates violations; the grant is simply recomputed each cycle.
- Pointer arithmetic: the wrap comparison is against N-1, never against 2^SW-1. For N=3 the pointer cycles 0→1→2→0.
- Starvation bound: a continuously valid channel is granted within N accepts.

## Timing
- Reset (`rst_n`=0 at a rising edge), taking effect the same edge:
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - `in_ready`=0 for as long as `rst_n`=0.
- Reset mid-operation discards any held beat without handshake. It is the consumer's responsibility to tolerate this.
- Latency: an input accepted at edge k appears on `out_*` after edge k. The first cycle it can be consumed is the cycle after acceptance.
- No combinational path from `in_data` to `out_data`.
- Combinational path exists from `in_valid` and `out_ready` to `in_ready`. It is a single arbitration level and must be kept at the top of the logic depth budget.
- All outputs other than `in_ready` come straight from flops.

## Configuration
- Macro: `MUX_RR_ARB_FIXED_PRIO_EN`.
- Undefined (default): round-robin as above.
- Defined:
  - Fixed priority, where the lowest index with `in_valid` set wins.
  - `ptr` is removed from the design and scanning always starts at 0.
  - Load, handshake, latency and reset behaviour are identical.
  - The starvation bound does not apply.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with all `in_valid`=1 → `out_valid`=0, `out_sel`=0, `in_ready`=0; after release, the first accept is channel 0.
2. **Round-robin under full load:** W=4, N=4, `in_valid`=4'b1111, data 4'hA/B/C/D on ch0..3, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0; `out_data` A,B,C,D,A; `out_valid` continuously 1 after the first beat.
3. **Backpressure:** `out_ready`=0 for 5 cycles while FULL with `out_data`=4'h5 → outputs stable, `in_ready`=0, `ptr` unchanged; `out_ready`=1 → 4'h5 consumed and the next grant is taken in the same cycle.
4. **Sparse requests and skip:** `ptr`=1, only ch3 valid (4'h9) → ch3 granted, `ptr` wraps to 0; then ch0 and ch3 valid → ch0 granted.
5. **Non-power-of-two:** N=3, all valid → `out_sel` 0,1,2,0,1; value 3 never appears.
6. **Configuration:** with `MUX_RR_ARB_FIXED_PRIO_EN` defined, all valid → `out_sel` stays 0 each cycle; drop ch0 → `out_sel`=1.

Source files
------------

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N:1 arbitrating mux, round-robin grant, registered output beat with valid/ready.
// Define MUX_RR_ARB_FIXED_PRIO_EN to use fixed lowest-index-first priority with no pointer.
module mux_rr_arb #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          load;
  logic          accept;
  logic          grant_hit;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] scan_idx;
  logic [SW-1:0] scan_start;
  logic [W-1:0]  grant_data;

  // Channel index reached k steps after start, wrapping at N (not at 2^SW).
  function automatic int wrap_idx(input int start, input int k);
    int s;
    s = start + k;
    if (s >= N) s = s - N;
    return s;
  endfunction

`ifdef MUX_RR_ARB_FIXED_PRIO_EN
  assign scan_start = '0;
`else
  logic [SW-1:0] ptr;

  assign scan_start = ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  assign out_valid = (state == FULL);
  assign load      = (state == EMPTY) || out_ready;
  assign accept    = |in_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = SW'(wrap_idx(int'(scan_start), k));
      if (!grant_hit && in_valid[scan_idx]) begin
        grant_hit = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == SW'(k)) grant_data = in_data[k*W +: W];
    end
  end

  // Reset gates the handshake so nothing is accepted while rst_n is low.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && grant_hit) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (accept)         state_nxt = FULL;
    else if (out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data <= grant_data;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: N=4 and N=3 instances driven by directed per-cycle vectors.
// Expected grants follow the build mode selected by MUX_RR_ARB_FIXED_PRIO_EN.
module tb_mux_rr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;

  logic [2:0]  in_valid3, in_ready3;
  logic [11:0] in_data3;
  logic        out_valid3, out_ready3;
  logic [3:0]  out_data3;
  logic [1:0]  out_sel3;

  mux_rr_arb #(.W(4), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_rr_arb #(.W(4), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3), .out_ready(out_ready3)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] data;
  } beat_t;

  // One row per cycle: inputs, expected in_ready for each mode, expected out_valid before the edge.
  typedef struct packed {
    logic [3:0]  v;
    logic        r;
    logic [15:0] d;
    logic [3:0]  rr;
    logic [3:0]  fp;
    logic        ov;
  } vec_t;

  beat_t      q4[$];
  beat_t      q3[$];
  vec_t       vecs [20];
  logic [1:0] sel3_exp [5];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [3:0]  exp_rdy;
  logic [1:0]  exp_idx;
  logic [15:0] cur_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin : mon4
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL n4_unexpected_beat: got sel %0d data %0h expected none", out_sel, out_data);
      end else begin
        e = q4.pop_front();
        check("n4_out_sel", out_sel, e.sel);
        check("n4_out_data", out_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon3
    beat_t e;
    if (rst_n && out_valid3 && out_ready3) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL n3_unexpected_beat: got sel %0d data %0h expected none", out_sel3, out_data3);
      end else begin
        e = q3.pop_front();
        check("n3_out_sel", out_sel3, e.sel);
        check("n3_out_data", out_data3, e.data);
      end
    end
  end

  initial begin
    //            v        r     d         rr       fp       ov
    vecs[0]  = '{4'b1111, 1'b1, 16'hDCBA, 4'b0001, 4'b0001, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 16'hDCBA, 4'b0010, 4'b0001, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 16'hDCBA, 4'b0100, 4'b0001, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 16'hDCBA, 4'b1000, 4'b0001, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 16'hDCBA, 4'b0001, 4'b0001, 1'b1};
    vecs[5]  = '{4'b1110, 1'b1, 16'hDC5A, 4'b0010, 4'b0010, 1'b1};
    vecs[6]  = '{4'b1111, 1'b0, 16'hDC5A, 4'b0000, 4'b0000, 1'b1};
    vecs[7]  = '{4'b1111, 1'b0, 16'hDC5A, 4'b0000, 4'b0000, 1'b1};
    vecs[8]  = '{4'b1111, 1'b0, 16'hDC5A, 4'b0000, 4'b0000, 1'b1};
    vecs[9]  = '{4'b1111, 1'b0, 16'hDC5A, 4'b0000, 4'b0000, 1'b1};
    vecs[10] = '{4'b1111, 1'b0, 16'hDC5A, 4'b0000, 4'b0000, 1'b1};
    vecs[11] = '{4'b1111, 1'b1, 16'hDC5A, 4'b0100, 4'b0001, 1'b1};
    vecs[12] = '{4'b0001, 1'b1, 16'hDC5A, 4'b0001, 4'b0001, 1'b1};
    vecs[13] = '{4'b1000, 1'b1, 16'h9C5A, 4'b1000, 4'b1000, 1'b1};
    vecs[14] = '{4'b1001, 1'b1, 16'h9C5A, 4'b0001, 4'b0001, 1'b1};
    vecs[15] = '{4'b0000, 1'b1, 16'h9C5A, 4'b0000, 4'b0000, 1'b1};
    vecs[16] = '{4'b0100, 1'b0, 16'h9C5A, 4'b0100, 4'b0100, 1'b0};
    vecs[17] = '{4'b0000, 1'b0, 16'h9C5A, 4'b0000, 4'b0000, 1'b1};
    vecs[18] = '{4'b0000, 1'b1, 16'h9C5A, 4'b0000, 4'b0000, 1'b1};
    vecs[19] = '{4'b0000, 1'b1, 16'h9C5A, 4'b0000, 4'b0000, 1'b0};
`ifdef MUX_RR_ARB_FIXED_PRIO_EN
    sel3_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    sel3_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
`endif

    rst_n      = 1'b0;
    in_valid   = 4'b1111;
    in_data    = 16'hDCBA;
    out_ready  = 1'b0;
    in_valid3  = 3'b111;
    in_data3   = 12'h654;
    out_ready3 = 1'b0;
    #1;
    check("rst_in_ready_comb", in_ready, 4'b0000);

    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sel", out_sel, 2'd0);
      check("rst_out_data", out_data, 4'h0);
      check("rst_in_ready", in_ready, 4'b0000);
      check("rst_in_ready3", in_ready3, 3'b000);
      check("rst_out_valid3", out_valid3, 1'b0);
    end

    rst_n      = 1'b1;
    out_ready3 = 1'b1;

    for (int i = 0; i < 20; i++) begin
      in_valid  = vecs[i].v;
      out_ready = vecs[i].r;
      in_data   = vecs[i].d;
      in_valid3 = (i < 5) ? 3'b111 : 3'b000;
      #1;
`ifdef MUX_RR_ARB_FIXED_PRIO_EN
      exp_rdy = vecs[i].fp;
`else
      exp_rdy = vecs[i].rr;
`endif
      check($sformatf("n4_in_ready_v%0d", i), in_ready, exp_rdy);
      check($sformatf("n4_out_valid_v%0d", i), out_valid, vecs[i].ov);
      if (exp_rdy != 4'b0000) begin
        exp_idx = oh2idx(exp_rdy);
        cur_d   = vecs[i].d;
        q4.push_back('{sel: exp_idx, data: cur_d[exp_idx*4 +: 4]});
      end
      if (i >= 6 && i <= 11) begin
        check($sformatf("hold_out_data_v%0d", i), out_data, 4'h5);
        check($sformatf("hold_out_sel_v%0d", i), out_sel, 2'd1);
      end
      if (i == 16) begin
        check("drained_out_data_held", out_data, 4'hA);
        check("drained_out_sel_held", out_sel, 2'd0);
      end
      if (i < 5) begin
        check($sformatf("n3_in_ready_v%0d", i), in_ready3, 3'b001 << sel3_exp[i]);
        q3.push_back('{sel: sel3_exp[i], data: 4'd4 + 4'(sel3_exp[i])});
      end
      @(posedge clk);
      #1;
    end

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("n4_scoreboard_drained", q4.size(), 0);
    check("n3_scoreboard_drained", q3.size(), 0);
    check("n3_out_valid_idle", out_valid3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
